// File: rtl/fuzzy_pkg.sv
// Shared types, constants and rule arithmetic helpers for the fuzzy inference path.
package fuzzy_pkg;

  localparam int N_RULES   = 4;
  localparam int DIV_STEPS = 16;

  localparam logic [15:0] Q15_ONE = 16'h7FFF;
  localparam logic [7:0]  PCT_MAX = 8'd100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RULE  = 2'd1,
    DIV   = 2'd2,
    SCALE = 2'd3
  } fis_state_t;

  function automatic logic [15:0] q15_min(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  // Percent 0..100 to Q1.15, rounded; 100 % maps to full scale 0x7FFF.
  function automatic logic [15:0] g_percent_to_q15(input logic [7:0] g);
    logic [7:0]  g_clamped;
    logic [22:0] scaled;
    g_clamped = (g > PCT_MAX) ? PCT_MAX : g;
    scaled    = 23'(g_clamped) * 23'd32767 + 23'd50;
    return 16'(scaled / 23'd100);
  endfunction

endpackage

// File: rtl/q15_div_restoring.sv
// Restoring divider: one quotient bit per cycle, MSB first; quotient forced to 0 on a zero divisor.
module q15_div_restoring
  import fuzzy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [19:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic        zero_div
);

  logic        busy_reg;
  logic [3:0]  step_reg;
  logic [35:0] rem_reg;
  logic [19:0] div_reg;
  logic [15:0] q_reg;

  logic [35:0] shifted;
  logic        fits;
  logic [35:0] rem_next;
  logic [15:0] q_next;

  always_comb begin
    shifted          = 36'(div_reg) << step_reg;
    fits             = (rem_reg >= shifted);
    rem_next         = fits ? (rem_reg - shifted) : rem_reg;
    q_next           = q_reg;
    q_next[step_reg] = fits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= 1'b0;
      step_reg <= '0;
      rem_reg  <= '0;
      div_reg  <= '0;
      q_reg    <= '0;
    end else if (start && !busy_reg) begin
      busy_reg <= 1'b1;
      step_reg <= 4'(DIV_STEPS - 1);
      rem_reg  <= 36'(dividend);
      div_reg  <= divisor;
      q_reg    <= '0;
    end else if (busy_reg) begin
      rem_reg <= rem_next;
      q_reg   <= q_next;
      if (step_reg == 4'd0) begin
        busy_reg <= 1'b0;
      end else begin
        step_reg <= step_reg - 4'd1;
      end
    end
  end

  // The final bit is presented combinationally so the caller can register the result on the last step.
  assign busy     = busy_reg;
  assign done     = busy_reg && (step_reg == 4'd0);
  assign zero_div = (div_reg == 20'd0);
  assign quot     = zero_div ? 16'd0 : q_next;

endmodule

// File: rtl/fuzzy_infer_seq.sv
// Sequential fuzzy inference: 4 corner rules through one shared multiplier, then a weighted-average divide.
module fuzzy_infer_seq
  import fuzzy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] t_neg,
  input  logic [15:0] t_pos,
  input  logic [15:0] dt_neg,
  input  logic [15:0] dt_pos,
  input  logic [7:0]  g_00,
  input  logic [7:0]  g_02,
  input  logic [7:0]  g_20,
  input  logic [7:0]  g_22,
  output logic        busy,
  output logic        done,
  output logic [15:0] g_q15,
  output logic [7:0]  g_pct,
  output logic        zero_w,
  output logic [19:0] S_w,
  output logic [31:0] S_wg
);

  fis_state_t state_reg, state_next;

  logic [15:0] t_neg_reg, t_pos_reg, dt_neg_reg, dt_pos_reg;
  logic [7:0]  g_in  [N_RULES];
  logic [7:0]  g_reg [N_RULES];
  logic [1:0]  k_reg;
  logic [19:0] acc_w_reg;
  logic [31:0] acc_wg_reg;

  logic [15:0] g_q15_reg;
  logic [7:0]  g_pct_reg;
  logic        zero_w_reg;
  logic [19:0] s_w_reg;
  logic [31:0] s_wg_reg;

  logic        accept;
  logic        last_rule;
  logic [15:0] t_sel, dt_sel, w, gq;
  logic [31:0] prod;
  logic [19:0] acc_w_next;
  logic [31:0] acc_wg_next;

  logic        div_start, div_busy, div_done, div_zero;
  logic [15:0] div_quot;
  logic [15:0] q_sat;
  logic [22:0] pct_wide;
  logic [7:0]  pct_val;

  assign g_in[0] = g_00;
  assign g_in[1] = g_02;
  assign g_in[2] = g_20;
  assign g_in[3] = g_22;

  assign accept    = (state_reg == IDLE) && start;
  assign last_rule = (state_reg == RULE) && (k_reg == 2'(N_RULES - 1));

  // Rule order 00,02,20,22: k[1] picks the temperature side, k[0] the derivative side.
  always_comb begin
    t_sel       = k_reg[1] ? t_pos_reg  : t_neg_reg;
    dt_sel      = k_reg[0] ? dt_pos_reg : dt_neg_reg;
    w           = q15_min(t_sel, dt_sel);
    gq          = g_percent_to_q15(g_reg[k_reg]);
    prod        = 32'(w) * 32'(gq);
    acc_w_next  = acc_w_reg + 20'(w);
    acc_wg_next = acc_wg_reg + prod;
  end

  assign div_start = last_rule && !div_busy;

  q15_div_restoring u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_wg_next),
    .divisor  (acc_w_next),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot),
    .zero_div (div_zero)
  );

  always_comb begin
    q_sat    = (div_quot > Q15_ONE) ? Q15_ONE : div_quot;
    pct_wide = (23'(q_sat) * 23'd100 + 23'd16384) >> 15;
    pct_val  = (pct_wide > 23'(PCT_MAX)) ? PCT_MAX : pct_wide[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RULE;
      RULE:    if (k_reg == 2'(N_RULES - 1)) state_next = DIV;
      DIV:     if (div_done) state_next = SCALE;
      SCALE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == SCALE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_RULES; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst) begin
          g_reg[gi] <= '0;
        end else if (accept) begin
          g_reg[gi] <= g_in[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      t_neg_reg  <= '0;
      t_pos_reg  <= '0;
      dt_neg_reg <= '0;
      dt_pos_reg <= '0;
      k_reg      <= '0;
      acc_w_reg  <= '0;
      acc_wg_reg <= '0;
      g_q15_reg  <= '0;
      g_pct_reg  <= '0;
      zero_w_reg <= 1'b0;
      s_w_reg    <= '0;
      s_wg_reg   <= '0;
    end else begin
      if (accept) begin
        t_neg_reg  <= t_neg;
        t_pos_reg  <= t_pos;
        dt_neg_reg <= dt_neg;
        dt_pos_reg <= dt_pos;
        k_reg      <= '0;
        acc_w_reg  <= '0;
        acc_wg_reg <= '0;
      end
      if (state_reg == RULE) begin
        acc_w_reg  <= acc_w_next;
        acc_wg_reg <= acc_wg_next;
        k_reg      <= k_reg + 2'd1;
      end
      // Results land on the divider's last step so they are visible during the done cycle.
      if ((state_reg == DIV) && div_done) begin
        g_q15_reg  <= q_sat;
        g_pct_reg  <= pct_val;
        zero_w_reg <= div_zero;
        s_w_reg    <= acc_w_reg;
        s_wg_reg   <= acc_wg_reg;
      end
    end
  end

  assign g_q15  = g_q15_reg;
  assign g_pct  = g_pct_reg;
  assign zero_w = zero_w_reg;
  assign S_w    = s_w_reg;
  assign S_wg   = s_wg_reg;

endmodule
